// File: rtl/imem_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : imem_sram_bridge
// Brief    : SCR1 imem request/response to single-port SRAM bank bridge with
//            preload write port and saturating error-response counter.
// Revision : 1.0 - initial release
// ============================================================================
module imem_sram_bridge #(
  parameter int                         IMEM_ADDR_WIDTH      = 32,
  parameter int                         SRAM_BANK_ADDR_WIDTH = 14,
  parameter int                         SRAM_BANK_DATA_WIDTH = 32,
  parameter logic [IMEM_ADDR_WIDTH-1:0] BASE_ADDR            = '0
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            imem_req,
  input  logic                            imem_cmd,
  input  logic [IMEM_ADDR_WIDTH-1:0]      imem_addr,
  output logic                            imem_req_ack,
  output logic [31:0]                     imem_rdata,
  output logic [1:0]                      imem_resp,
  input  logic                            load_en,
  input  logic [SRAM_BANK_ADDR_WIDTH-1:0] load_addr,
  input  logic [SRAM_BANK_DATA_WIDTH-1:0] load_data,
  output logic [SRAM_BANK_ADDR_WIDTH-1:0] mem_addr,
  output logic [SRAM_BANK_DATA_WIDTH-1:0] mem_wdata,
  output logic                            mem_we,
  output logic                            mem_ce,
  input  logic [SRAM_BANK_DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]                     o_err_cnt
);

  localparam logic [1:0]  c_RESP_IDLE  = 2'b00;
  localparam logic [1:0]  c_RESP_OKAY  = 2'b01;
  localparam logic [1:0]  c_RESP_ERROR = 2'b10;
  localparam logic [15:0] c_CNT_MAX    = 16'hFFFF;

  logic [IMEM_ADDR_WIDTH-1:0] w_off;
  logic                       w_aligned;
  logic                       w_above_base;
  logic                       w_in_range;
  logic                       w_ack;
  logic                       w_ok;
  logic                       w_rd;
  logic                       w_err;

  logic [1:0]                 r_pend;
  logic [15:0]                r_err_cnt;

  // Offset wraps modulo 2**IMEM_ADDR_WIDTH; low-address rejection comes from
  // the explicit compare below, never from the wrapped value.
  assign w_off        = imem_addr - BASE_ADDR;
  // BASE_ADDR is word aligned, so the offset low bits equal the address low bits.
  assign w_aligned    = (w_off[1:0] == 2'b00);
  assign w_above_base = (imem_addr >= BASE_ADDR);

  generate
    if (IMEM_ADDR_WIDTH > SRAM_BANK_ADDR_WIDTH + 2) begin : g_range_cmp
      assign w_in_range = ~|w_off[IMEM_ADDR_WIDTH-1:SRAM_BANK_ADDR_WIDTH+2];
    end else begin : g_range_all
      assign w_in_range = 1'b1;
    end
  endgenerate

  assign w_ack        = imem_req & ~load_en;
  assign w_ok         = ~imem_cmd & w_aligned & w_above_base & w_in_range;
  assign w_rd         = w_ack & w_ok;
  assign w_err        = w_ack & ~w_ok;
  assign imem_req_ack = w_ack;

  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (load_en) begin
      mem_ce    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = load_addr;
      mem_wdata = load_data;
    end else if (w_rd) begin
      mem_ce    = 1'b1;
      mem_addr  = w_off[SRAM_BANK_ADDR_WIDTH+1:2];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend    <= c_RESP_IDLE;
      r_err_cnt <= '0;
    end else begin
      if (w_rd) begin
        r_pend <= c_RESP_OKAY;
      end else if (w_err) begin
        r_pend <= c_RESP_ERROR;
      end else begin
        r_pend <= c_RESP_IDLE;
      end
      if (w_err && (r_err_cnt != c_CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign imem_resp  = r_pend;
  assign imem_rdata = (r_pend == c_RESP_OKAY) ? mem_rdata[31:0] : 32'd0;
  assign o_err_cnt  = r_err_cnt;

endmodule
`default_nettype wire
